latch_selftest_engine: RTL and testbench
========================================

Name: latch_selftest_engine

Overview:
- Synthesizable stimulus and check engine for the team's NAND-based D latch.
- Drives the latch's D and E inputs from a fixed 8-entry vector table, waits a settle interval, then samples Q and Qbar.
- Compares the samples against a golden expected value, counts mismatches and records the first failing vector.
- Sits beside the latch as its on-chip driver and checker, replacing manual stimulus-and-display checking.

Parameters:
- SETTLE_CYC, 1, cycles the engine holds each vector before sampling the DUT; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begins a run when sampled high in IDLE or DONE
- dut_q  input  1  latch Q output
- dut_qbar  input  1  latch Qbar output
- dut_d  output  1  latch D input, registered
- dut_e  output  1  latch E (enable) input, registered
- busy  output  1  high while a run is in progress
- done  output  1  high from run completion until the next start or rst
- pass  output  1  done && (err_count == 0)
- err_count  output  4  number of failing vectors in the current/last run, 0..8
- fail_idx  output  3  index of the first failing vector; meaningful only when err_count != 0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all outputs 0 (dut_d=0, dut_e=0, busy=0, done=0, pass=0, err_count=0, fail_idx=0). State=IDLE, idx=0, settle counter=0.
- Reset mid-run aborts immediately to these values; no partial result is retained.
- Vector table, listed as idx: (E, D) -> expected Q:
  - 0: (1,1) -> 1
  - 1: (0,0) -> 1
  - 2: (0,1) -> 1
  - 3: (1,0) -> 0
  - 4: (1,1) -> 1
  - 5: (0,0) -> 1
  - 6: (1,0) -> 0
  - 7: (0,1) -> 0
  - Vector 0 has E=1, so the latch state is known before any hold vector.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE or DONE, with start=1:
  - Clear err_count and fail_idx; set idx=0.
  - Load dut_e/dut_d from vector 0.
  - busy=1, done=0; counter=SETTLE_CYC-1; go to SETTLE.
- IDLE with start=0: stay.
- DONE with start=0: stay; done, pass, err_count and fail_idx hold.
- SETTLE: if counter==0 go to CHECK, else decrement. Vector held exactly SETTLE_CYC cycles.
- CHECK (one cycle): sample dut_q and dut_qbar on the exiting edge.
  - A vector fails if dut_q != expected OR dut_qbar != ~expected. Each vector counts at most once.
  - On a fail: err_count += 1. If err_count was 0, fail_idx = idx.
  - If idx < 7: idx += 1; load the next vector onto dut_e/dut_d; counter=SETTLE_CYC-1; go to SETTLE.
  - If idx == 7: go to DONE; busy=0, done=1. pass is computed with the final count, including vector 7's result.
- dut_d and dut_e change only on vector-load edges and hold between them.
- Latency: from the start-sampling edge to the edge asserting done is 8*(SETTLE_CYC+1) cycles. With the default SETTLE_CYC=1 this is 16.
- start while busy (SETTLE/CHECK) is ignored.
- err_count is 4 bits and cannot overflow (maximum 8).
- pass is never high while busy.
- Simultaneous rst and start: rst wins.
- dut_q/dut_qbar are sampled only in CHECK; X or glitches in other states are don't-care.

Test Plan:
- Ideal behavioural latch attached, SETTLE_CYC=1, start pulsed one cycle -> done rises 16 cycles after the start edge; pass=1, err_count=0; busy high for exactly 16 cycles.
- Latch model with Q stuck at 0, Qbar=1 -> done; err_count=5 (vectors 0,1,2,4,5); fail_idx=0; pass=0.
- Faulty latch that ignores E (Q=D, Qbar=~D) -> err_count=3 (vectors 1,5,7); fail_idx=1; pass=0.
- Ideal Q but Qbar tied to Q -> every vector fails: err_count=8, fail_idx=0, pass=0.
- Assert rst at cycle 5 of a run -> next cycle all outputs are 0 and the FSM is in IDLE. A new start with the ideal latch then completes with pass=1. A start pulse at cycle 3 of that run has no effect on timing.
- SETTLE_CYC=3 with the ideal latch -> done rises 32 cycles after start. dut_e/dut_d each hold 4 cycles per vector, following the vector table sequence. A second start from DONE re-runs with err_count cleared first.

Source files
------------

// File: rtl/latch_selftest_engine_if.sv
// Bus between the self-test engine and the NAND D latch under test.
interface latch_selftest_engine_if;
   logic dut_d;
   logic dut_e;
   logic dut_q;
   logic dut_qbar;

   // Engine side: drives D/E, observes Q/Qbar
   modport master (output dut_d, output dut_e, input dut_q, input dut_qbar);
   // Latch side: consumes D/E, produces Q/Qbar
   modport slave  (input dut_d, input dut_e, output dut_q, output dut_qbar);
endinterface

// File: rtl/latch_selftest_engine.sv
// Stimulus and check engine for the NAND-based D latch: walks an 8-entry
// (E, D) vector table, holds each vector, samples Q/Qbar and tallies failures.
module latch_selftest_engine #(
   parameter int unsigned SETTLE_CYC = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   latch_selftest_engine_if.master        lat,
   output logic                           busy,
   output logic                           done,
   output logic                           pass,
   output logic [3:0]                     err_count,
   output logic [2:0]                     fail_idx
);

   typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC - 1);

   state_t     state_q;
   logic [2:0] idx_q;
   logic [3:0] cnt_q;
   logic       d_q;
   logic       e_q;
   logic       busy_q;
   logic       done_q;
   logic       pass_q;
   logic [3:0] err_q;
   logic [2:0] fidx_q;

   logic [2:0] idx_d;
   logic [2:0] vec_cur;
   logic [2:0] vec_nxt;
   logic [2:0] vec_first;
   logic       vec_fail;
   logic [3:0] err_d;

   // Vector table entry as {E, D, expected Q}
   function automatic logic [2:0] vec_lookup(input logic [2:0] i);
      case (i)
         3'd0:    return 3'b111;
         3'd1:    return 3'b001;
         3'd2:    return 3'b011;
         3'd3:    return 3'b100;
         3'd4:    return 3'b111;
         3'd5:    return 3'b001;
         3'd6:    return 3'b100;
         default: return 3'b010;
      endcase
   endfunction

   // Current-vector verdict and next-vector lookup
   always_comb begin
      idx_d     = idx_q + 3'd1;
      vec_cur   = vec_lookup(idx_q);
      vec_nxt   = vec_lookup(idx_d);
      vec_first = vec_lookup(3'd0);
      vec_fail  = (lat.dut_q != vec_cur[0]) || (lat.dut_qbar != ~vec_cur[0]);
      err_d     = err_q + 4'(vec_fail);
   end

   // Run sequencer with registered stimulus and result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         d_q     <= 1'b0;
         e_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         fidx_q  <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  err_q   <= '0;
                  fidx_q  <= '0;
                  idx_q   <= '0;
                  e_q     <= vec_first[2];
                  d_q     <= vec_first[1];
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
                  cnt_q   <= CNT_LOAD;
                  state_q <= SETTLE;
               end
            end
            SETTLE: begin
               if (cnt_q == '0) state_q <= CHECK;
               else             cnt_q   <= cnt_q - 4'd1;
            end
            CHECK: begin
               err_q <= err_d;
               if (vec_fail && (err_q == '0)) fidx_q <= idx_q;
               if (idx_q != 3'd7) begin
                  idx_q   <= idx_d;
                  e_q     <= vec_nxt[2];
                  d_q     <= vec_nxt[1];
                  cnt_q   <= CNT_LOAD;
                  state_q <= SETTLE;
               end else begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  // pass uses the count including vector 7's verdict
                  pass_q  <= (err_d == '0);
                  state_q <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign lat.dut_d = d_q;
   assign lat.dut_e = e_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_idx  = fidx_q;

endmodule

// File: tb/tb_latch_selftest_engine.sv
// Directed bench for latch_selftest_engine with behavioural latch models.
module tb_latch_selftest_engine;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start0 = 1'b0;
   logic start1 = 1'b0;
   int   mode = 0; // 0 ideal, 1 Q stuck 0, 2 ignores E, 3 Qbar tied to Q

   logic busy0, done0, pass0, busy1, done1, pass1;
   logic [3:0] err0, err1;
   logic [2:0] fidx0, fidx1;

   int checks = 0;
   int errors = 0;

   // Hand-written vector table, bit i = vector i
   logic [7:0] tv_e = 8'b0101_1001;
   logic [7:0] tv_d = 8'b1001_0101;

   latch_selftest_engine_if lif0 ();
   latch_selftest_engine_if lif1 ();

   always #5 clk = ~clk;

   latch_selftest_engine #(.SETTLE_CYC(1)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .lat(lif0),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_idx(fidx0)
   );

   latch_selftest_engine #(.SETTLE_CYC(3)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .lat(lif1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_idx(fidx1)
   );

   // Behavioural latches with selectable faults
   logic lq0, lq1;
   always_latch if (lif0.dut_e) lq0 <= lif0.dut_d;
   always_latch if (lif1.dut_e) lq1 <= lif1.dut_d;

   assign lif0.dut_q    = (mode == 1) ? 1'b0 : (mode == 2) ? lif0.dut_d : lq0;
   assign lif0.dut_qbar = (mode == 1) ? 1'b1 : (mode == 2) ? ~lif0.dut_d :
                          (mode == 3) ? lq0 : ~lq0;
   assign lif1.dut_q    = (mode == 1) ? 1'b0 : (mode == 2) ? lif1.dut_d : lq1;
   assign lif1.dut_qbar = (mode == 1) ? 1'b1 : (mode == 2) ? ~lif1.dut_d :
                          (mode == 3) ? lq1 : ~lq1;

   // Pulse start on the chosen engine, then count cycles until done (bounded).
   // inject_at >= 0 pulses start again that many cycles into the run.
   task automatic run_engine(input int sel, input int inject_at,
                             output int lat, output int bcyc);
      int n;
      @(negedge clk);
      if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
      n = 0;
      bcyc = ((sel == 0) ? busy0 : busy1) ? 1 : 0;
      while (!((sel == 0) ? done0 : done1) && n < 200) begin
         if (n == inject_at) begin
            if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
         end
         @(negedge clk);
         start0 = 1'b0;
         start1 = 1'b0;
         n++;
         if ((sel == 0) ? busy0 : busy1) bcyc++;
      end
      lat = n;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy0, done0, pass0, err0, fidx0, lif0.dut_d, lif0.dut_e} !== 13'd0) begin
         errors++;
         $display("FAIL reset_outputs got %b want 0", {busy0, done0, pass0, err0, fidx0, lif0.dut_d, lif0.dut_e});
      end
      checks++;
      if ({busy1, done1, pass1, lif1.dut_d, lif1.dut_e} !== 5'd0) begin
         errors++;
         $display("FAIL reset_outputs_s3 got %b want 0", {busy1, done1, pass1, lif1.dut_d, lif1.dut_e});
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy0, done0} !== 2'b00) begin
         errors++;
         $display("FAIL idle_no_start got %b want 00", {busy0, done0});
      end
   endtask

   task automatic test_ideal();
      int lat, bc;
      mode = 0;
      run_engine(0, -1, lat, bc);
      checks++;
      if (lat != 16) begin errors++; $display("FAIL ideal_latency got %0d want 16", lat); end
      checks++;
      if (bc != 16) begin errors++; $display("FAIL ideal_busy_cycles got %0d want 16", bc); end
      checks++;
      if ({done0, pass0, busy0, err0} !== 7'b1100000) begin
         errors++;
         $display("FAIL ideal_result got done=%b pass=%b busy=%b err=%0d want 1 1 0 0", done0, pass0, busy0, err0);
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({done0, pass0, err0} !== 6'b110000) begin
         errors++;
         $display("FAIL done_hold got done=%b pass=%b err=%0d want 1 1 0", done0, pass0, err0);
      end
   endtask

   task automatic test_stuck0();
      int lat, bc;
      mode = 1;
      run_engine(0, -1, lat, bc);
      checks++;
      if (lat != 16 || done0 !== 1'b1) begin errors++; $display("FAIL stuck0_latency got %0d want 16", lat); end
      checks++;
      if (err0 !== 4'd5) begin errors++; $display("FAIL stuck0_err got %0d want 5", err0); end
      checks++;
      if (fidx0 !== 3'd0) begin errors++; $display("FAIL stuck0_fidx got %0d want 0", fidx0); end
      checks++;
      if (pass0 !== 1'b0) begin errors++; $display("FAIL stuck0_pass got %b want 0", pass0); end
   endtask

   task automatic test_ignore_e();
      int lat, bc;
      mode = 2;
      run_engine(0, -1, lat, bc);
      checks++;
      if (err0 !== 4'd3) begin errors++; $display("FAIL ignore_e_err got %0d want 3", err0); end
      checks++;
      if (fidx0 !== 3'd1) begin errors++; $display("FAIL ignore_e_fidx got %0d want 1", fidx0); end
      checks++;
      if ({done0, pass0} !== 2'b10) begin errors++; $display("FAIL ignore_e_pass got %b want 10", {done0, pass0}); end
   endtask

   task automatic test_qbar_eq_q();
      int lat, bc;
      mode = 3;
      run_engine(0, -1, lat, bc);
      checks++;
      if (err0 !== 4'd8) begin errors++; $display("FAIL qbarq_err got %0d want 8", err0); end
      checks++;
      if (fidx0 !== 3'd0) begin errors++; $display("FAIL qbarq_fidx got %0d want 0", fidx0); end
      checks++;
      if ({done0, pass0} !== 2'b10) begin errors++; $display("FAIL qbarq_pass got %b want 10", {done0, pass0}); end
   endtask

   task automatic test_reset_midrun();
      int lat, bc;
      mode = 2; // non-zero partial count would otherwise be visible
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy0, done0, pass0, err0, fidx0, lif0.dut_d, lif0.dut_e} !== 13'd0) begin
         errors++;
         $display("FAIL midrun_reset got %b want 0", {busy0, done0, pass0, err0, fidx0, lif0.dut_d, lif0.dut_e});
      end
      repeat (4) @(negedge clk);
      checks++;
      if ({busy0, done0, lif0.dut_e} !== 3'b000) begin
         errors++;
         $display("FAIL midrun_stays_idle got %b want 000", {busy0, done0, lif0.dut_e});
      end
      mode = 0;
      run_engine(0, 3, lat, bc);
      checks++;
      if (lat != 16) begin errors++; $display("FAIL busy_start_ignored got %0d want 16", lat); end
      checks++;
      if ({pass0, err0} !== 5'b10000) begin errors++; $display("FAIL post_reset_pass got pass=%b err=%0d want 1 0", pass0, err0); end
   endtask

   task automatic test_settle3();
      int n, lat, bc, vi, seq_bad;
      mode = 0;
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      seq_bad = 0;
      while (!done1 && n < 200) begin
         vi = n / 4;
         if (vi < 8 && (lif1.dut_e !== tv_e[vi] || lif1.dut_d !== tv_d[vi])) begin
            if (seq_bad == 0)
               $display("FAIL s3_vector_seq cycle %0d got e=%b d=%b want e=%b d=%b",
                        n, lif1.dut_e, lif1.dut_d, tv_e[vi], tv_d[vi]);
            seq_bad++;
         end
         @(negedge clk);
         n++;
      end
      checks++;
      if (seq_bad != 0) errors++;
      checks++;
      if (n != 32) begin errors++; $display("FAIL s3_latency got %0d want 32", n); end
      checks++;
      if ({pass1, err1} !== 5'b10000) begin errors++; $display("FAIL s3_pass got pass=%b err=%0d want 1 0", pass1, err1); end
      // Faulty run leaves a non-zero count; a fresh start must clear it
      mode = 1;
      run_engine(1, -1, lat, bc);
      checks++;
      if (err1 !== 4'd5) begin errors++; $display("FAIL s3_stuck0_err got %0d want 5", err1); end
      mode = 0;
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      checks++;
      if ({err1, fidx1, done1, pass1, busy1} !== 10'b0000_000_001) begin
         errors++;
         $display("FAIL s3_restart_clear got err=%0d fidx=%0d done=%b pass=%b busy=%b want 0 0 0 0 1",
                  err1, fidx1, done1, pass1, busy1);
      end
      n = 0;
      while (!done1 && n < 200) begin @(negedge clk); n++; end
      checks++;
      if (n != 32 || {pass1, err1} !== 5'b10000) begin
         errors++;
         $display("FAIL s3_rerun got lat=%0d pass=%b err=%0d want 32 1 0", n, pass1, err1);
      end
   endtask

   initial begin
      test_reset();
      test_ideal();
      test_stuck0();
      test_ignore_e();
      test_qbar_eq_q();
      test_reset_midrun();
      test_settle3();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
